// File: rtl/counter_ctrl_unit.sv
// Run/stop/clear/mode button controller and tick divider for a 0-9999 counter.
// Optional per-button debounce filter enabled by defining CU_DEBOUNCE_EN.
module counter_ctrl_unit #(
  parameter int TICK_DIV        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_run,
  input  logic i_btn_clear,
  input  logic i_btn_mode,
  output logic o_tick,
  output logic o_mode,
  output logic o_clear,
  output logic o_run
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  localparam logic [1:0] S_STOP  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("counter_ctrl_unit: TICK_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  // Bit order everywhere: [0] run, [1] clear, [2] mode.
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] level;
  logic [2:0] level_q;
  logic [2:0] armed;
  logic [2:0] press;
  logic       settled;

  assign btn_raw = {i_btn_mode, i_btn_clear, i_btn_run};

  // A button is armed only once it has been seen released after reset, so a
  // button held through reset release cannot fake a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level_q <= '0;
      armed   <= '0;
      settled <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= level;
      settled <= 1'b1;
      armed   <= armed | (~sync1 & ~sync2 & {3{settled}});
    end
  end

`ifdef CU_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [2:0]     filt;
  logic [DBW-1:0] db_cnt [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  assign press = level & ~level_q & armed;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [DW-1:0] div_cnt;
  logic          stay_run;

  always_comb begin
    next_state = state;
    case (state)
      S_STOP: begin
        if (press[0])      next_state = S_RUN;
        else if (press[1]) next_state = S_CLEAR;
      end
      S_RUN: begin
        if (press[0]) next_state = S_STOP;
      end
      S_CLEAR: next_state = S_STOP;
      default: next_state = S_STOP;
    endcase
  end

  assign stay_run = (state == S_RUN) && (next_state == S_RUN);

  // Divider only advances while RUN persists; any exit or entry restarts it at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_STOP;
      div_cnt <= '0;
      o_tick  <= 1'b0;
      o_mode  <= 1'b0;
      o_clear <= 1'b0;
      o_run   <= 1'b0;
    end else begin
      state   <= next_state;
      o_run   <= (next_state == S_RUN);
      o_clear <= (next_state == S_CLEAR);
      o_tick  <= stay_run && (div_cnt == DIV_LAST);
      if (press[2]) o_mode <= ~o_mode;
      if (!stay_run || div_cnt == DIV_LAST) div_cnt <= '0;
      else                                  div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: doc/counter_ctrl_unit.md
COUNTER_CTRL_UNIT -- requirements
Module: counter_ctrl_unit

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10_000_000; clocks per o_tick period (10 Hz at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000; stable-level count used only when CU_DEBOUNCE_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port i_btn_run, input, 1, raw run/stop button, asynchronous to clk.
REQ-006 SHALL have port i_btn_clear, input, 1, raw clear button, asynchronous to clk.
REQ-007 SHALL have port i_btn_mode, input, 1, raw up/down mode button, asynchronous to clk.
REQ-008 SHALL have port o_tick, output, 1, one-cycle count-enable pulse to the downstream 0-9999 counter.
REQ-009 SHALL have port o_mode, output, 1, count direction: 0 = up, 1 = down.
REQ-010 SHALL have port o_clear, output, 1, one-cycle counter clear pulse.
REQ-011 SHALL have port o_run, output, 1, high while in RUN.

Function
REQ-012 SHALL pass each button through a 2-flop synchroniser, then the optional filter (REQ-030/031), then a rising-edge detector giving a one-cycle press event.
REQ-013 SHALL apply a press to state/outputs on the 3rd rising clk edge after the raw input is first sampled high (filter disabled); held buttons produce exactly one event.
REQ-014 SHALL implement an FSM with states STOP, RUN, CLEAR; reset state STOP.
REQ-015 STOP: run press -> RUN; clear press without run press -> CLEAR; otherwise stay.
REQ-016 RUN: run press -> STOP; clear press ignored.
REQ-017 CLEAR: unconditional -> STOP after exactly one cycle; all presses in that cycle ignored.
REQ-018 STOP with simultaneous run and clear presses SHALL go to RUN (run has priority).
REQ-019 o_clear SHALL be 1 exactly while state is CLEAR (one-cycle pulse), registered.
REQ-020 o_run SHALL be 1 exactly while state is RUN, registered.
REQ-021 Mode press SHALL toggle o_mode in any state, including same cycle as run/clear presses; o_mode not affected by CLEAR.
REQ-022 Tick divider SHALL be a ceil(log2(TICK_DIV))-bit counter, held at 0 outside RUN, incrementing in RUN, wrapping TICK_DIV-1 -> 0.
REQ-023 o_tick SHALL pulse for one cycle when the divider wraps; first pulse TICK_DIV cycles after entering RUN, then every TICK_DIV cycles.
REQ-024 Leaving RUN SHALL zero the divider in the same edge; o_tick never asserted outside RUN; a pause/resume restarts the full TICK_DIV period.
REQ-025 o_tick and o_clear SHALL never be high in the same cycle.

Reset
REQ-026 rst high at a rising edge SHALL set state STOP, o_tick 0, o_mode 0, o_clear 0, o_run 0, divider 0, synchroniser/edge/filter registers 0.
REQ-027 rst SHALL override all presses in the same cycle; reset mid-RUN SHALL produce no further o_tick.
REQ-028 A button held high through reset release SHALL not generate a press until released and pressed again.

Configuration
REQ-029 Macro CU_DEBOUNCE_EN SHALL select the button filter.
REQ-030 Defined: each synchronised button SHALL change filtered level only after DEBOUNCE_CYCLES consecutive identical samples; press latency increases by DEBOUNCE_CYCLES; shorter glitches produce no event.
REQ-031 Undefined: filtered level equals synchronised level; no filter counters synthesised; parameter DEBOUNCE_CYCLES unused.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4)
REQ-032 Reset, run press -> o_run=1 3 edges later; o_tick pulses at cycles 10, 20, 30 after RUN entry, each 1 cycle wide.
REQ-033 In RUN, run press at divider=6 -> STOP, no tick; second run press -> next tick exactly 10 cycles after re-entry.
REQ-034 In STOP, clear press -> o_clear=1 for exactly 1 cycle then STOP; in RUN, clear press -> o_clear stays 0.
REQ-035 STOP, run and clear pressed same cycle -> RUN, o_clear never asserts; mode press held 50 cycles -> o_mode toggles once.
REQ-036 CU_DEBOUNCE_EN defined: 3-cycle run glitch -> no state change; 6-cycle press -> RUN after 3+4 edges.
REQ-037 rst asserted 4 cycles into RUN with o_mode=1 -> next edge all outputs 0, STOP, no tick for 30 cycles.
